// File: rtl/noc_pkg.sv
// Shared NoC definitions: command encodings, header field layout and the
// transmit arbiter state type.
package noc_pkg;

  typedef enum logic [2:0] {
    NOC_CMD_NOP        = 3'b000,
    NOC_CMD_READ       = 3'b001,
    NOC_CMD_WRITE      = 3'b010,
    NOC_CMD_READ_RESP  = 3'b011,
    NOC_CMD_WRITE_RESP = 3'b100,
    NOC_CMD_MSG        = 3'b101
  } noc_cmd_t;

  localparam logic [7:0] NOC_NOP_BYTE = 8'h00;
  localparam logic [7:0] MSG_ERR      = 8'h03;

  localparam int unsigned HDR_ALEN_LSB = 6;
  localparam int unsigned HDR_ALEN_W   = 2;
  localparam int unsigned HDR_DLEN_LSB = 3;
  localparam int unsigned HDR_DLEN_W   = 3;
  localparam int unsigned HDR_CMD_LSB  = 0;
  localparam int unsigned HDR_CMD_W    = 3;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_SEND = 1'b1
  } arb_state_t;

  function automatic logic [7:0] noc_hdr(input noc_cmd_t cmd,
                                         input logic [1:0] alen,
                                         input logic [2:0] dlen);
    return {alen, dlen, cmd};
  endfunction

  function automatic noc_cmd_t noc_hdr_cmd(input logic [7:0] hdr);
    return noc_cmd_t'(hdr[HDR_CMD_LSB +: HDR_CMD_W]);
  endfunction

endpackage

// File: rtl/noc_tx_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set bit of (req & mask)
// scanning upward from ptr, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  input  logic [N-1:0]  i_mask,
  output logic          o_valid,
  output logic [IW-1:0] o_index
);

  always_comb begin
    int unsigned w_pos;
    logic [IW-1:0] w_j;
    o_valid = 1'b0;
    o_index = '0;
    w_pos   = 0;
    w_j     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_pos = 32'(i_ptr) + k;
      if (w_pos >= N) w_pos = w_pos - N;
      w_j = IW'(w_pos);
      if (!o_valid && i_req[w_j] && i_mask[w_j]) begin
        o_valid = 1'b1;
        o_index = w_j;
      end
    end
  end

endmodule

// File: rtl/noc_tx_arbiter.sv
// Packet-level round-robin arbiter sharing the byte-serial NoC transmit link
// between NREQ sources; holds the grant for a whole packet, NOP when idle.
module noc_tx_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LENW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*LENW-1:0] len,
  input  logic [NREQ*8-1:0] byte_in,
  output logic [NREQ-1:0]   rd,
  output logic [NREQ-1:0]   gnt,
  output logic              noc_from_dev_ctl,
  output logic [7:0]        noc_from_dev_data,
  output logic              len_err
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t       r_state;
  logic [NREQ-1:0]  r_gnt;
  logic [IW-1:0]    r_owner;
  logic [IW-1:0]    r_ptr;
  logic [LENW-1:0]  r_cnt;
  logic             r_first;
  logic             r_ctl;
  logic [7:0]       r_data;
  logic             r_len_err;

  logic             w_valid;
  logic [IW-1:0]    w_idx;
  logic [NREQ-1:0]  w_mask;
  logic [NREQ-1:0]  w_win_oh;
  logic [LENW-1:0]  w_win_len;
  logic [IW-1:0]    w_next_ptr;
  logic [7:0]       w_head;
  logic             w_last;

  // One picker serves both idle arbitration and the last-byte handover; the
  // owner is masked out during SEND because its pop completes this cycle.
  assign w_mask = (r_state == ARB_SEND) ? ~r_gnt : '1;

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .i_mask  (w_mask),
    .o_valid (w_valid),
    .o_index (w_idx)
  );

  assign w_win_len  = len[w_idx*LENW +: LENW];
  assign w_next_ptr = (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
  assign w_head     = byte_in[r_owner*8 +: 8];
  assign w_last     = (r_cnt == LENW'(1));

  always_comb begin
    w_win_oh        = '0;
    w_win_oh[w_idx] = 1'b1;
  end

  always_comb begin
    rd = (r_state == ARB_SEND) ? r_gnt : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ARB_IDLE;
      r_gnt     <= '0;
      r_owner   <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_first   <= 1'b0;
      r_ctl     <= 1'b1;
      r_data    <= NOC_NOP_BYTE;
      r_len_err <= 1'b0;
    end else begin
      r_len_err <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          r_ctl  <= 1'b1;
          r_data <= NOC_NOP_BYTE;
          if (w_valid) begin
            r_ptr <= w_next_ptr;
            if (w_win_len != '0) begin
              r_gnt   <= w_win_oh;
              r_owner <= w_idx;
              r_cnt   <= w_win_len;
              r_first <= 1'b1;
              r_state <= ARB_SEND;
            end else begin
              r_len_err <= 1'b1;
            end
          end
        end
        ARB_SEND: begin
          r_ctl   <= r_first;
          r_first <= 1'b0;
          r_data  <= w_head;
          r_cnt   <= r_cnt - 1'b1;
          if (w_last) begin
            if (w_valid && (w_win_len != '0)) begin
              r_ptr   <= w_next_ptr;
              r_gnt   <= w_win_oh;
              r_owner <= w_idx;
              r_cnt   <= w_win_len;
              r_first <= 1'b1;
            end else begin
              if (w_valid) begin
                r_ptr     <= w_next_ptr;
                r_len_err <= 1'b1;
              end
              r_gnt   <= '0;
              r_state <= ARB_IDLE;
            end
          end
        end
        default: begin
          r_gnt   <= '0;
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

  assign gnt               = r_gnt;
  assign noc_from_dev_ctl  = r_ctl;
  assign noc_from_dev_data = r_data;
  assign len_err           = r_len_err;

endmodule
